coin_accumulator: RTL

COIN_ACCUMULATOR -- requirements
Module: coin_accumulator

---
 rtl/coin_pkg.sv | 30 +++
 rtl/coin_accumulator.sv | 138 +++++++++++++
 2 files changed

// File: rtl/coin_pkg.sv
// rtl/coin_pkg.sv - coin encodings, values and FSM states shared by the vending datapath blocks
package coin_pkg;

  typedef enum logic [1:0] {
    COIN_NONE    = 2'b00,
    COIN_NICKEL  = 2'b01,
    COIN_DIME    = 2'b10,
    COIN_QUARTER = 2'b11
  } coin_type_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_PAYOUT  = 2'd2
  } coin_state_e;

  localparam logic [7:0] NICKEL_C  = 8'd5;
  localparam logic [7:0] DIME_C    = 8'd10;
  localparam logic [7:0] QUARTER_C = 8'd25;

  function automatic logic [7:0] coin_value(input coin_type_e ct);
    case (ct)
      COIN_NICKEL:  return NICKEL_C;
      COIN_DIME:    return DIME_C;
      COIN_QUARTER: return QUARTER_C;
      default:      return 8'd0;
    endcase
  endfunction

endpackage

// File: rtl/coin_accumulator.sv
// rtl/coin_accumulator.sv - accumulates coins against a latched price, vends and holds change until acked
module coin_accumulator #(
  parameter int unsigned MAX_PRICE = 75
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       coin_valid,
  input  logic [1:0] coin_type,
  input  logic [7:0] price,
  input  logic       cancel,
  input  logic       change_ack,
  output logic [7:0] total,
  output logic       vend,
  output logic [7:0] change,
  output logic       change_valid,
  output logic       coin_reject
);
  import coin_pkg::*;

  localparam logic [7:0] MAX_PRICE_C = 8'(MAX_PRICE);

  coin_state_e state_q, state_d;
  logic [7:0]  price_q, price_d;
  logic [7:0]  total_q, total_d;
  logic [7:0]  change_q, change_d;
  logic        change_valid_q, change_valid_d;
  logic        vend_q, vend_d;
  logic        coin_reject_q, coin_reject_d;

  logic [7:0]  eff_price;
  logic [7:0]  new_total;
  logic [7:0]  excess;
  logic        price_ok;
  logic        coin_accept;
  logic        cancel_go;
  logic        paid;

  // The live price only matters on the first coin; afterwards the latched copy governs.
  always_comb begin
    eff_price   = (state_q == ST_IDLE) ? price : price_q;
    price_ok    = (eff_price >= 8'd5) && (eff_price <= MAX_PRICE_C) &&
                  ((eff_price % 8'd5) == 8'd0);
    cancel_go   = cancel && (state_q == ST_COLLECT);
    coin_accept = coin_valid && (state_q != ST_PAYOUT) &&
                  (coin_type != COIN_NONE) && price_ok && !cancel;
    new_total   = total_q + coin_value(coin_type_e'(coin_type));
    paid        = new_total >= eff_price;
    excess      = new_total - eff_price;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_COLLECT: begin
        if (cancel_go) begin
          state_d = ST_PAYOUT;
        end else if (coin_accept) begin
          if (!paid) begin
            state_d = ST_COLLECT;
          end else if (excess != 8'd0) begin
            state_d = ST_PAYOUT;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_PAYOUT: begin
        if (change_ack) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    price_d        = price_q;
    total_d        = total_q;
    change_d       = change_q;
    change_valid_d = change_valid_q;
    vend_d         = 1'b0;
    coin_reject_d  = coin_valid && !coin_accept;
    if (cancel_go) begin
      change_d       = total_q;
      change_valid_d = 1'b1;
      total_d        = 8'd0;
    end else if (coin_accept) begin
      if (state_q == ST_IDLE) begin
        price_d = price;
      end
      if (paid) begin
        vend_d         = 1'b1;
        total_d        = 8'd0;
        change_d       = excess;
        change_valid_d = (excess != 8'd0);
      end else begin
        total_d = new_total;
      end
    end
    if ((state_q == ST_PAYOUT) && change_ack) begin
      change_d       = 8'd0;
      change_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      price_q        <= 8'd0;
      total_q        <= 8'd0;
      change_q       <= 8'd0;
      change_valid_q <= 1'b0;
      vend_q         <= 1'b0;
      coin_reject_q  <= 1'b0;
    end else begin
      price_q        <= price_d;
      total_q        <= total_d;
      change_q       <= change_d;
      change_valid_q <= change_valid_d;
      vend_q         <= vend_d;
      coin_reject_q  <= coin_reject_d;
    end
  end

  assign total        = total_q;
  assign vend         = vend_q;
  assign change       = change_q;
  assign change_valid = change_valid_q;
  assign coin_reject  = coin_reject_q;

endmodule
